// File: rtl/prt_dp_msg_pkg.sv
// ---------------------------------------------------------------------------
// prt_dp_msg_pkg
// Shared definitions for the message-ring master: header field positions,
// the send FSM state encoding and the header packing helper.
// ---------------------------------------------------------------------------
package prt_dp_msg_pkg;

    // Header word layout: {DIR, ID[6:0], LEN[7:0]}
    localparam int unsigned HDR_DIR_BIT = 15;
    localparam int unsigned HDR_ID_MSB  = 14;
    localparam int unsigned HDR_ID_LSB  = 8;
    localparam int unsigned HDR_LEN_MSB = 7;
    localparam int unsigned HDR_LEN_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DAT  = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic logic [15:0] hdr_pack(input logic       get,
                                             input logic [6:0] id,
                                             input logic [7:0] len);
        logic [15:0] h;
        h                          = '0;
        h[HDR_DIR_BIT]             = get;
        h[HDR_ID_MSB:HDR_ID_LSB]   = id;
        h[HDR_LEN_MSB:HDR_LEN_LSB] = len;
        return h;
    endfunction

endpackage

// File: rtl/prt_dp_msg_if.sv
// ---------------------------------------------------------------------------
// prt_dp_msg_if
// One hop of the message ring.
//   som : first word (header) of a message
//   eom : last word of a message
//   vld : word qualifier; som/eom/dat are meaningful only with vld=1
//   dat : 16-bit ring word
// Modports: src drives a hop, snk observes a hop.
// ---------------------------------------------------------------------------
interface prt_dp_msg_if;
    logic        som;
    logic        eom;
    logic        vld;
    logic [15:0] dat;

    modport src (output som, eom, vld, dat);
    modport snk (input  som, eom, vld, dat);
endinterface

// File: rtl/prt_dp_msg_mst_ret.sv
// ---------------------------------------------------------------------------
// prt_dp_msg_mst_ret
// Return-path matcher for the ring master. Finds the master's own message on
// the looped-back ring, counts its data words, forwards get data to the host
// and reports completion and length mismatch.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   en_i              : matching enabled (command in flight); low clears state
//   hdr_i             : header of the message in flight
//   snk_*_i           : ring return word
//   ret_eom_o         : own message eom seen this cycle (combinational)
//   ret_len_err_o     : with ret_eom_o, word count differed from LEN+1
//   ret_done_o        : own message already completed (sticky while en_i)
//   rd_dat_o/vld_o/last_o : registered get data to the host
// ---------------------------------------------------------------------------
module prt_dp_msg_mst_ret
    import prt_dp_msg_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic [15:0] hdr_i,
    input  logic        snk_som_i,
    input  logic        snk_eom_i,
    input  logic        snk_vld_i,
    input  logic [15:0] snk_dat_i,
    output logic        ret_eom_o,
    output logic        ret_len_err_o,
    output logic        ret_done_o,
    output logic [15:0] rd_dat_o,
    output logic        rd_vld_o,
    output logic        rd_last_o
);

    logic        match_q, match_d;
    logic        done_q, done_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [15:0] rd_dat_q, rd_dat_d;
    logic        rd_vld_q, rd_vld_d;
    logic        rd_last_q, rd_last_d;
    logic        hit;
    logic        word;

    always_comb begin
        // Only the first header equal to ours opens a match; foreign
        // messages and later copies are passed over.
        hit  = en_i && !match_q && !done_q && snk_vld_i && snk_som_i &&
               (snk_dat_i == hdr_i);
        word = en_i && match_q && snk_vld_i;

        ret_eom_o = (hit || word) && snk_eom_i;
        // cnt_q holds the words seen before this one, so the eom word is the
        // (cnt_q+1)-th; equality with LEN+1 reduces to cnt_q == LEN. An eom on
        // the header itself carries zero data words and is always short.
        ret_len_err_o = ret_eom_o &&
                        (hit || (cnt_q != {1'b0, hdr_i[HDR_LEN_MSB:HDR_LEN_LSB]}));

        match_d   = match_q;
        done_d    = done_q;
        cnt_d     = cnt_q;
        rd_dat_d  = rd_dat_q;
        rd_vld_d  = 1'b0;
        rd_last_d = 1'b0;

        if (!en_i) begin
            match_d = 1'b0;
            done_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            if (hit) begin
                match_d = 1'b1;
                cnt_d   = '0;
            end
            // Saturate so an overlong return still reads as a mismatch
            if (word && (cnt_q != 9'h1FF)) begin
                cnt_d = cnt_q + 9'd1;
            end
            if (ret_eom_o) begin
                match_d = 1'b0;
                done_d  = 1'b1;
            end
        end

        // Put returns are discarded; only get data reaches the host
        if (word && hdr_i[HDR_DIR_BIT]) begin
            rd_vld_d  = 1'b1;
            rd_dat_d  = snk_dat_i;
            rd_last_d = snk_eom_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            match_q   <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            rd_dat_q  <= '0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            match_q   <= match_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            rd_dat_q  <= rd_dat_d;
            rd_vld_q  <= rd_vld_d;
            rd_last_q <= rd_last_d;
        end
    end

    assign ret_done_o = done_q;
    assign rd_dat_o   = rd_dat_q;
    assign rd_vld_o   = rd_vld_q;
    assign rd_last_o  = rd_last_q;

endmodule

// File: rtl/prt_dp_msg_mst.sv
// ---------------------------------------------------------------------------
// prt_dp_msg_mst
// Message-ring master. Turns a host command into a ring message (header plus
// LEN+1 data words), then waits for the message to come back around the ring.
// Get data overwritten by the addressed slave is handed to the host.
//   CLK_IN, RST_IN   : clock, asynchronous active-low reset
//   MSG_SRC_IF       : ring output (registered)
//   MSG_SNK_IF       : ring return (tail of ring, looped back)
//   CMD_*            : command handshake and fields
//   WR_*             : put data handshake
//   RD_*             : get data strobe (registered)
//   BUSY_OUT         : command in flight
//   ERR_OUT          : sticky timeout / length error, cleared on next accept
//   DBG_STATE_OUT    : current send FSM state
//
// Handshakes (CMD, WR): the producer holds VLD and its data stable until the
// consumer shows RDY; a transfer happens on every clock edge where VLD && RDY.
// RDY never depends combinationally on VLD.
// ---------------------------------------------------------------------------
module prt_dp_msg_mst
    import prt_dp_msg_pkg::*;
#(
    parameter int unsigned            P_DAT_WIDTH = 16,
    parameter int unsigned            P_TMO_WIDTH = 16,
    parameter logic [P_TMO_WIDTH-1:0] P_TMO       = 16'hFFFF
) (
    input  logic                   CLK_IN,
    input  logic                   RST_IN,
    prt_dp_msg_if.src              MSG_SRC_IF,
    prt_dp_msg_if.snk              MSG_SNK_IF,
    input  logic                   CMD_VLD_IN,
    output logic                   CMD_RDY_OUT,
    input  logic                   CMD_GET_IN,
    input  logic [6:0]             CMD_ID_IN,
    input  logic [7:0]             CMD_LEN_IN,
    input  logic [P_DAT_WIDTH-1:0] WR_DAT_IN,
    input  logic                   WR_VLD_IN,
    output logic                   WR_RDY_OUT,
    output logic [P_DAT_WIDTH-1:0] RD_DAT_OUT,
    output logic                   RD_VLD_OUT,
    output logic                   RD_LAST_OUT,
    output logic                   BUSY_OUT,
    output logic                   ERR_OUT,
    output logic [2:0]             DBG_STATE_OUT
);

    state_t                 state_q, state_d;
    logic [15:0]            hdr_q, hdr_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [P_TMO_WIDTH-1:0] tmo_q, tmo_d;
    logic                   som_q, som_d;
    logic                   eom_q, eom_d;
    logic                   vld_q, vld_d;
    logic [15:0]            dat_q, dat_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;
    logic                   cmd_rdy_q, cmd_rdy_d;
    logic                   wr_rdy;
    logic                   send;
    logic                   last_word;
    logic                   ret_en;
    logic                   ret_eom;
    logic                   ret_len_err;
    logic                   ret_done;

    // Matching opens once the header is latched; the return may overlap DAT
    assign ret_en = (state_q == ST_HDR) || (state_q == ST_DAT) || (state_q == ST_WAIT);

    prt_dp_msg_mst_ret u_ret (
        .clk_i         (CLK_IN),
        .rst_ni        (RST_IN),
        .en_i          (ret_en),
        .hdr_i         (hdr_q),
        .snk_som_i     (MSG_SNK_IF.som),
        .snk_eom_i     (MSG_SNK_IF.eom),
        .snk_vld_i     (MSG_SNK_IF.vld),
        .snk_dat_i     (MSG_SNK_IF.dat),
        .ret_eom_o     (ret_eom),
        .ret_len_err_o (ret_len_err),
        .ret_done_o    (ret_done),
        .rd_dat_o      (RD_DAT_OUT),
        .rd_vld_o      (RD_VLD_OUT),
        .rd_last_o     (RD_LAST_OUT)
    );

    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        err_d     = err_q;
        som_d     = 1'b0;
        eom_d     = 1'b0;
        vld_d     = 1'b0;
        dat_d     = '0;
        wr_rdy    = 1'b0;
        send      = 1'b0;
        last_word = (cnt_q == hdr_q[HDR_LEN_MSB:HDR_LEN_LSB]);

        case (state_q)
            ST_IDLE: begin
                // cmd_rdy_q is only ever high in IDLE
                if (CMD_VLD_IN && cmd_rdy_q) begin
                    hdr_d   = hdr_pack(CMD_GET_IN, CMD_ID_IN, CMD_LEN_IN);
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                som_d   = 1'b1;
                vld_d   = 1'b1;
                dat_d   = hdr_q;
                state_d = ST_DAT;
            end
            ST_DAT: begin
                if (hdr_q[HDR_DIR_BIT]) begin
                    // Get: zero placeholders, one per cycle, no bubbles
                    send = 1'b1;
                end else begin
                    wr_rdy = 1'b1;
                    send   = WR_VLD_IN;
                end
                if (send) begin
                    vld_d = 1'b1;
                    eom_d = last_word;
                    dat_d = hdr_q[HDR_DIR_BIT] ? 16'h0000 : WR_DAT_IN;
                    cnt_d = cnt_q + 8'd1;
                    if (last_word) begin
                        if (ret_eom || ret_done) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_WAIT;
                            tmo_d   = P_TMO;
                        end
                    end
                end
            end
            ST_WAIT: begin
                tmo_d = tmo_q - 1'b1;
                // A return eom in the expiry cycle still completes cleanly
                if (ret_eom) begin
                    state_d = ST_DONE;
                end else if (tmo_q <= P_TMO_WIDTH'(1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (ret_eom && ret_len_err) begin
            err_d = 1'b1;
        end

        cmd_rdy_d = (state_d == ST_IDLE);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            state_q   <= ST_IDLE;
            hdr_q     <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            som_q     <= 1'b0;
            eom_q     <= 1'b0;
            vld_q     <= 1'b0;
            dat_q     <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            cmd_rdy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_q     <= hdr_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            som_q     <= som_d;
            eom_q     <= eom_d;
            vld_q     <= vld_d;
            dat_q     <= dat_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            cmd_rdy_q <= cmd_rdy_d;
        end
    end

    assign MSG_SRC_IF.som = som_q;
    assign MSG_SRC_IF.eom = eom_q;
    assign MSG_SRC_IF.vld = vld_q;
    assign MSG_SRC_IF.dat = dat_q;
    assign CMD_RDY_OUT    = cmd_rdy_q;
    assign WR_RDY_OUT     = wr_rdy;
    assign BUSY_OUT       = busy_q;
    assign ERR_OUT        = err_q;
    assign DBG_STATE_OUT  = state_q;

endmodule
